// File: rtl/pu_riscv_rf_mp.sv
// Multi-port RISC-V integer register file with debug access and post-reset zero-clear sequence.
// Latency: reads registered, one cycle, write-first bypass; writes land at the clock edge.
// Backpressure: none; rf_busy is high while the clear walks registers 1..2^AR_BITS-1.
module pu_riscv_rf_mp #(
    parameter int XLEN    = 64,
    parameter int AR_BITS = 5,
    parameter int RDPORTS = 2,
    parameter int WRPORTS = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [RDPORTS*AR_BITS-1:0] rf_src,
    output logic [RDPORTS*XLEN-1:0]    rf_srcv,
    input  logic [WRPORTS*AR_BITS-1:0] rf_dst,
    input  logic [WRPORTS*XLEN-1:0]    rf_dstv,
    input  logic [WRPORTS-1:0]         rf_we,
    input  logic                       du_stall,
    input  logic                       du_we_rf,
    input  logic [XLEN-1:0]            du_dato,
    output logic [XLEN-1:0]            du_dati_rf,
    input  logic [11:0]                du_addr,
    output logic                       rf_busy
);

    localparam int NWR   = WRPORTS + 1;
    localparam int DEPTH = 1 << AR_BITS;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    logic [0:0]         state;
    logic [AR_BITS-1:0] clr_cnt;
    logic [XLEN-1:0]    mem [DEPTH];

    logic [NWR-1:0]     wr_en;
    logic [AR_BITS-1:0] wr_addr [NWR];
    logic [XLEN-1:0]    wr_dat  [NWR];

    logic [AR_BITS-1:0] rd_addr  [RDPORTS];
    logic [XLEN-1:0]    srcv_nxt [RDPORTS];
    logic [XLEN-1:0]    dati_nxt;
    logic [AR_BITS-1:0] du_reg;
    logic               du_addr_unused;

    assign du_reg         = du_addr[AR_BITS-1:0];
    assign du_addr_unused = ^du_addr[11:AR_BITS];
    assign rf_busy        = (state == ST_CLEAR);

    // Port NWR-1 is shared: it carries the clear walk in CLEAR and the debug write in RUN.
    // Core ports come first so a higher index wins on an address collision.
    always_comb begin
        for (int i = 0; i < WRPORTS; i++) begin
            wr_addr[i] = rf_dst[i*AR_BITS +: AR_BITS];
            wr_dat[i]  = rf_dstv[i*XLEN +: XLEN];
            wr_en[i]   = (state == ST_RUN) && !du_stall && rf_we[i] && (wr_addr[i] != '0);
        end
        if (state == ST_CLEAR) begin
            wr_addr[NWR-1] = clr_cnt;
            wr_dat[NWR-1]  = '0;
            wr_en[NWR-1]   = (clr_cnt != '0);
        end else begin
            wr_addr[NWR-1] = du_reg;
            wr_dat[NWR-1]  = du_dato;
            wr_en[NWR-1]   = du_stall && du_we_rf && (du_reg != '0);
        end
    end

    // Read path: array contents, overridden by any write landing on the same address.
    always_comb begin
        for (int p = 0; p < RDPORTS; p++) begin
            rd_addr[p]  = rf_src[p*AR_BITS +: AR_BITS];
            srcv_nxt[p] = mem[rd_addr[p]];
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k] == rd_addr[p])) begin
                    srcv_nxt[p] = wr_dat[k];
                end
            end
            if (rd_addr[p] == '0) begin
                srcv_nxt[p] = '0;
            end
        end

        dati_nxt = mem[du_reg];
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && (wr_addr[k] == du_reg)) begin
                dati_nxt = wr_dat[k];
            end
        end
        if (du_reg == '0) begin
            dati_nxt = '0;
        end
    end

    // Storage is not on the reset net; only the clear walk defines its contents.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k]) begin
                mem[wr_addr[k]] <= wr_dat[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= ST_CLEAR;
            clr_cnt <= AR_BITS'(1);
        end else if (state == ST_CLEAR) begin
            clr_cnt <= clr_cnt + AR_BITS'(1);
            if (clr_cnt == '1) begin
                state <= ST_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rf_srcv    <= '0;
            du_dati_rf <= '0;
        end else begin
            for (int p = 0; p < RDPORTS; p++) begin
                rf_srcv[p*XLEN +: XLEN] <= srcv_nxt[p];
            end
            du_dati_rf <= dati_nxt;
        end
    end

endmodule

// File: tb/tb_pu_riscv_rf_mp.sv
// Bench for pu_riscv_rf_mp: directed scenarios plus random traffic against a sequential array model.
module tb_pu_riscv_rf_mp;

    localparam int XL   = 64;
    localparam int AB   = 5;
    localparam int RP   = 2;
    localparam int WP   = 2;
    localparam int NREG = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic [RP*AB-1:0]  rf_src;
    logic [RP*XL-1:0]  rf_srcv;
    logic [WP*AB-1:0]  rf_dst;
    logic [WP*XL-1:0]  rf_dstv;
    logic [WP-1:0]     rf_we;
    logic              du_stall;
    logic              du_we_rf;
    logic [XL-1:0]     du_dato;
    logic [XL-1:0]     du_dati_rf;
    logic [11:0]       du_addr;
    logic              rf_busy;

    pu_riscv_rf_mp #(.XLEN(XL), .AR_BITS(AB), .RDPORTS(RP), .WRPORTS(WP)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rf_src     (rf_src),
        .rf_srcv    (rf_srcv),
        .rf_dst     (rf_dst),
        .rf_dstv    (rf_dstv),
        .rf_we      (rf_we),
        .du_stall   (du_stall),
        .du_we_rf   (du_we_rf),
        .du_dato    (du_dato),
        .du_dati_rf (du_dati_rf),
        .du_addr    (du_addr),
        .rf_busy    (rf_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model: register array with a known-value flag, plus clear progress.
    logic [XL-1:0] m  [NREG];
    bit            mv [NREG];
    bit            mbusy;
    int            midx;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_outs();
        chk("busy", 64'(rf_busy), 64'(mbusy));
        for (int p = 0; p < RP; p++) begin
            int a;
            a = int'(rf_src[p*AB +: AB]);
            if (!rstn)
                chk($sformatf("srcv%0d_rst", p), rf_srcv[p*XL +: XL], 64'h0);
            else if (a == 0)
                chk($sformatf("srcv%0d_x0", p), rf_srcv[p*XL +: XL], 64'h0);
            else if (mv[a])
                chk($sformatf("srcv%0d_x%0d", p, a), rf_srcv[p*XL +: XL], m[a]);
        end
        begin
            int a;
            a = int'(du_addr[AB-1:0]);
            if (!rstn)
                chk("dati_rst", du_dati_rf, 64'h0);
            else if (a == 0)
                chk("dati_x0", du_dati_rf, 64'h0);
            else if (mv[a])
                chk($sformatf("dati_x%0d", a), du_dati_rf, m[a]);
        end
    endtask

    // One clock: apply the edge's writes to the model in port order, then compare reads.
    task automatic tick();
        @(posedge clk);
        if (rstn) begin
            if (mbusy) begin
                m[midx]  = '0;
                mv[midx] = 1'b1;
                midx++;
                if (midx == NREG) mbusy = 1'b0;
            end else if (!du_stall) begin
                for (int i = 0; i < WP; i++) begin
                    int d;
                    d = int'(rf_dst[i*AB +: AB]);
                    if (rf_we[i] && d != 0) begin
                        m[d]  = rf_dstv[i*XL +: XL];
                        mv[d] = 1'b1;
                    end
                end
            end else if (du_we_rf) begin
                int d;
                d = int'(du_addr[AB-1:0]);
                if (d != 0) begin
                    m[d]  = du_dato;
                    mv[d] = 1'b1;
                end
            end
        end
        #1;
        check_outs();
    endtask

    task automatic idle();
        rf_src   = '0;
        rf_dst   = '0;
        rf_dstv  = '0;
        rf_we    = '0;
        du_stall = 1'b0;
        du_we_rf = 1'b0;
        du_dato  = '0;
        du_addr  = '0;
    endtask

    task automatic set_wr(input int port, input int a, input logic [XL-1:0] d);
        rf_dst[port*AB +: AB]  = AB'(a);
        rf_dstv[port*XL +: XL] = d;
        rf_we[port]            = 1'b1;
    endtask

    task automatic set_rd(input int port, input int a);
        rf_src[port*AB +: AB] = AB'(a);
    endtask

    task automatic do_reset();
        rstn  = 1'b0;
        mbusy = 1'b1;
        midx  = 1;
        #1;
        check_outs();
        tick();
        tick();
        rstn = 1'b1;
    endtask

    task automatic count_busy(input string tag);
        int n;
        n = 0;
        while (rf_busy && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 64'(n), 64'd31);
    endtask

    function automatic int raddr();
        if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 7));
        return int'($urandom_range(0, NREG - 1));
    endfunction

    initial begin
        idle();
        rstn = 1'b0;

        // Clear ignores a core write held across the whole sequence.
        set_wr(0, 3, 64'hAA);
        do_reset();
        count_busy("busy_len_first");
        idle();
        set_rd(0, 3);
        tick();
        chk("x3_after_clear", rf_srcv[XL-1:0], 64'h0);

        // Same-cycle write/read bypass.
        idle();
        set_wr(0, 5, 64'h1234);
        set_rd(0, 5);
        tick();
        chk("bypass_x5", rf_srcv[XL-1:0], 64'h1234);
        idle();
        set_rd(1, 5);
        tick();
        chk("x5_port1", rf_srcv[2*XL-1:XL], 64'h1234);

        // Both core ports hit x7: port 1 wins.
        idle();
        set_wr(0, 7, 64'h11);
        set_wr(1, 7, 64'h22);
        set_rd(0, 7);
        set_rd(1, 7);
        tick();
        chk("x7_collide_byp", rf_srcv[2*XL-1:XL], 64'h22);
        idle();
        set_rd(0, 7);
        tick();
        chk("x7_collide", rf_srcv[XL-1:0], 64'h22);

        // x0 stays zero against core and debug writes.
        idle();
        set_wr(0, 0, 64'hFFFF);
        set_wr(1, 0, 64'hFFFF);
        tick();
        chk("x0_core_p0", rf_srcv[XL-1:0], 64'h0);
        idle();
        du_stall = 1'b1;
        du_we_rf = 1'b1;
        du_dato  = 64'hFFFF;
        tick();
        chk("x0_dbg_dati", du_dati_rf, 64'h0);
        chk("x0_dbg_p1", rf_srcv[2*XL-1:XL], 64'h0);

        // Debug write wins under stall; ignored without stall.
        idle();
        du_stall = 1'b1;
        du_we_rf = 1'b1;
        du_addr  = 12'h00A;
        du_dato  = 64'hBEEF;
        set_wr(0, 10, 64'h1);
        tick();
        idle();
        set_rd(0, 10);
        du_addr = 12'h00A;
        tick();
        chk("x10_dbg", rf_srcv[XL-1:0], 64'hBEEF);
        chk("x10_dbg_dati", du_dati_rf, 64'hBEEF);
        idle();
        du_we_rf = 1'b1;
        du_addr  = 12'h00A;
        du_dato  = 64'hBEEF;
        set_wr(0, 10, 64'h1);
        tick();
        idle();
        set_rd(0, 10);
        tick();
        chk("x10_core", rf_srcv[XL-1:0], 64'h1);

        // Upper debug address bits alias onto the register index.
        idle();
        du_stall = 1'b1;
        du_we_rf = 1'b1;
        du_addr  = 12'hF0B;
        du_dato  = 64'h77;
        tick();
        chk("x11_alias_byp", du_dati_rf, 64'h77);
        idle();
        set_rd(1, 11);
        tick();
        chk("x11_alias", rf_srcv[2*XL-1:XL], 64'h77);

        // Reset mid-clear restarts the full sequence.
        idle();
        set_wr(1, 20, 64'h55);
        tick();
        idle();
        do_reset();
        for (int i = 0; i < 10; i++) tick();
        do_reset();
        count_busy("busy_len_restart");
        idle();
        set_rd(0, 20);
        tick();
        chk("x20_after_restart", rf_srcv[XL-1:0], 64'h0);

        // Random traffic with one reset in the middle.
        for (int it = 0; it < 600; it++) begin
            if (it == 300) do_reset();
            for (int p = 0; p < RP; p++) set_rd(p, raddr());
            for (int i = 0; i < WP; i++) begin
                rf_dst[i*AB +: AB]  = AB'(raddr());
                rf_dstv[i*XL +: XL] = {$urandom, $urandom};
                rf_we[i]            = ($urandom_range(0, 2) != 0);
            end
            du_stall = ($urandom_range(0, 3) == 0);
            du_we_rf = ($urandom_range(0, 1) == 1);
            du_dato  = {$urandom, $urandom};
            du_addr  = {7'($urandom), 5'(raddr())};
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
